// File: rtl/azadi_pad_mux.sv
// Caravel pad multiplexer: per-pad function select with tri-state gap on switch,
// sticky configuration lock and an io_in synchronizer chain.
module azadi_pad_mux #(
  parameter int unsigned NUM_PADS    = 38,
  parameter int unsigned PAD_IDX_W   = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter logic [1:0]  RESET_SEL   = 2'd0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [PAD_IDX_W-1:0] cfg_pad,
  input  logic [1:0]           cfg_sel,
  input  logic                 cfg_lock,
  output logic                 cfg_err,
  output logic                 locked_o,
  input  logic [NUM_PADS-1:0]  gpio_o,
  input  logic [NUM_PADS-1:0]  gpio_oe,
  input  logic [NUM_PADS-1:0]  alt0_o,
  input  logic [NUM_PADS-1:0]  alt0_oe,
  input  logic [NUM_PADS-1:0]  alt1_o,
  input  logic [NUM_PADS-1:0]  alt1_oe,
  output logic [NUM_PADS-1:0]  pad_in_o,
  input  logic [NUM_PADS-1:0]  io_in,
  output logic [NUM_PADS-1:0]  io_out,
  output logic [NUM_PADS-1:0]  io_oeb
);

  typedef enum logic [1:0] {StIdle, StGap, StCommit} state_e;

  localparam logic [3:0] GapLoad = 4'(GAP_CYCLES - 1);

  state_e                     r_state, w_state_next;
  logic [3:0]                 r_gap_cnt;
  logic [PAD_IDX_W-1:0]       r_sw_pad;
  logic [1:0]                 r_sw_sel;
  logic [NUM_PADS-1:0][1:0]   r_sel;
  logic                       r_locked, r_err;
  logic [NUM_PADS-1:0]        r_io_out, r_io_oeb;
  logic [NUM_PADS-1:0]        w_drv_out, w_drv_oeb;
  logic [NUM_PADS-1:0]        r_sync [SYNC_STAGES];
  logic                       w_accept, w_pad_bad, w_reject, w_start;
  logic                       w_switching, w_commit;
  logic [1:0]                 w_cur_sel;

  // Request decode
  always_comb begin
    w_cur_sel = 2'd0;
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      if (cfg_pad == PAD_IDX_W'(p)) w_cur_sel = r_sel[p];
    end
  end

  assign w_pad_bad = (32'(cfg_pad) >= NUM_PADS);
  assign w_accept  = cfg_valid & cfg_ready;
  assign w_reject  = w_accept & (w_pad_bad | r_locked);
  assign w_start   = w_accept & ~w_reject & (cfg_sel != w_cur_sel);

  // FSM: state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_start) w_state_next = StGap;
      StGap:    if (r_gap_cnt == 4'd0) w_state_next = StCommit;
      StCommit: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_ready   = (r_state == StIdle) & ~wb_rst_i;
    w_switching = (r_state != StIdle);
    w_commit    = (r_state == StCommit);
  end

  // Select registers, gap counter, lock and error pulse
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_gap_cnt <= 4'd0;
      r_sw_pad  <= '0;
      r_sw_sel  <= 2'd0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_sel     <= {NUM_PADS{RESET_SEL}};
    end else begin
      r_err <= w_reject;
      if (w_accept && !w_reject && cfg_lock) r_locked <= 1'b1;
      if (w_start) begin
        r_sw_pad  <= cfg_pad;
        r_sw_sel  <= cfg_sel;
        r_gap_cnt <= GapLoad;
      end else if (r_state == StGap && r_gap_cnt != 4'd0) begin
        r_gap_cnt <= r_gap_cnt - 4'd1;
      end
      if (w_commit) begin
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
          if (r_sw_pad == PAD_IDX_W'(p)) r_sel[p] <= r_sw_sel;
        end
      end
    end
  end

  // Next pad drive; the pad being switched is parked tri-stated low
  always_comb begin
    w_drv_out = '0;
    w_drv_oeb = '1;
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      case (r_sel[p])
        2'd0: begin
          w_drv_out[p] = gpio_o[p];
          w_drv_oeb[p] = ~gpio_oe[p];
        end
        2'd1: begin
          w_drv_out[p] = alt0_o[p];
          w_drv_oeb[p] = ~alt0_oe[p];
        end
        2'd2: begin
          w_drv_out[p] = alt1_o[p];
          w_drv_oeb[p] = ~alt1_oe[p];
        end
        default: begin
          w_drv_out[p] = 1'b0;
          w_drv_oeb[p] = 1'b1;
        end
      endcase
      if (w_switching && r_sw_pad == PAD_IDX_W'(p)) begin
        w_drv_out[p] = 1'b0;
        w_drv_oeb[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_io_out <= '0;
      r_io_oeb <= '1;
    end else begin
      r_io_out <= w_drv_out;
      r_io_oeb <= w_drv_oeb;
    end
  end

  // Input synchronizer chain
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= io_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign pad_in_o = r_sync[SYNC_STAGES-1];
  assign io_out   = r_io_out;
  assign io_oeb   = r_io_oeb;
  assign cfg_err  = r_err;
  assign locked_o = r_locked;

endmodule

// File: tb/tb_azadi_pad_mux.sv
// Self-checking bench for azadi_pad_mux: cycle-level reference model compared every
// cycle, plus directed literal checks on the key switch, reject, lock and sync timings.
module tb_azadi_pad_mux;

  localparam int NUM_PADS  = 38;
  localparam int PAD_IDX_W = 6;
  localparam int SYNC      = 2;
  localparam int GAP       = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_valid, cfg_lock;
  logic [PAD_IDX_W-1:0] cfg_pad;
  logic [1:0]           cfg_sel;
  logic                 cfg_ready, cfg_err, locked_o;
  logic [NUM_PADS-1:0]  gpio_o, gpio_oe, alt0_o, alt0_oe, alt1_o, alt1_oe;
  logic [NUM_PADS-1:0]  io_in, pad_in_o, io_out, io_oeb;

  azadi_pad_mux #(
    .NUM_PADS    (NUM_PADS),
    .PAD_IDX_W   (PAD_IDX_W),
    .SYNC_STAGES (SYNC),
    .GAP_CYCLES  (GAP),
    .RESET_SEL   (2'd0)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_pad   (cfg_pad),
    .cfg_sel   (cfg_sel),
    .cfg_lock  (cfg_lock),
    .cfg_err   (cfg_err),
    .locked_o  (locked_o),
    .gpio_o    (gpio_o),
    .gpio_oe   (gpio_oe),
    .alt0_o    (alt0_o),
    .alt0_oe   (alt0_oe),
    .alt1_o    (alt1_o),
    .alt1_oe   (alt1_oe),
    .pad_in_o  (pad_in_o),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: tracks each pad's function and the one pending switch by cycle number
  logic [1:0]          m_sel [NUM_PADS];
  logic [NUM_PADS-1:0] hist [SYNC];
  logic [NUM_PADS-1:0] e_out, e_oeb, e_pin;
  bit                  m_valid = 0, m_locked = 0, m_busy = 0, e_err = 0;
  int                  m_sw_pad, m_sw_t;
  logic [1:0]          m_sw_sel;

  always @(posedge clk) begin
    int  t, pad_i;
    bit  acc, rej, forced;
    t = cyc;
    cyc++;
    if (rst) begin
      m_valid  = 1;
      m_locked = 0;
      m_busy   = 0;
      e_err    = 0;
      e_out    = '0;
      e_oeb    = '1;
      for (int p = 0; p < NUM_PADS; p++) m_sel[p] = 2'd0;
      for (int i = 0; i < SYNC; i++) hist[i] = '0;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        forced = m_busy && p == m_sw_pad && cyc >= m_sw_t + 2 && cyc <= m_sw_t + GAP + 2;
        if (forced || m_sel[p] == 2'd3) begin
          e_out[p] = 1'b0; e_oeb[p] = 1'b1;
        end else if (m_sel[p] == 2'd0) begin
          e_out[p] = gpio_o[p]; e_oeb[p] = !gpio_oe[p];
        end else if (m_sel[p] == 2'd1) begin
          e_out[p] = alt0_o[p]; e_oeb[p] = !alt0_oe[p];
        end else begin
          e_out[p] = alt1_o[p]; e_oeb[p] = !alt1_oe[p];
        end
      end
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = io_in;
      pad_i = int'(cfg_pad);
      acc   = cfg_valid && !m_busy;
      rej   = acc && (pad_i >= NUM_PADS || m_locked);
      e_err = rej;
      if (acc && !rej) begin
        if (cfg_lock) m_locked = 1;
        if (cfg_sel != m_sel[pad_i]) begin
          m_busy = 1; m_sw_pad = pad_i; m_sw_sel = cfg_sel; m_sw_t = t;
        end
      end
      if (m_busy && cyc == m_sw_t + GAP + 2) begin
        m_sel[m_sw_pad] = m_sw_sel;
        m_busy = 0;
      end
    end
    e_pin = hist[SYNC-1];
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("io_out",    64'(io_out),    64'(e_out));
      check("io_oeb",    64'(io_oeb),    64'(e_oeb));
      check("pad_in_o",  64'(pad_in_o),  64'(e_pin));
      check("cfg_err",   64'(cfg_err),   64'(e_err));
      check("locked_o",  64'(locked_o),  64'(m_locked));
      check("cfg_ready", 64'(cfg_ready), 64'(!rst && !m_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int pad, input logic [1:0] sel, input logic lck);
    cfg_valid = 1'b1;
    cfg_pad   = PAD_IDX_W'(pad);
    cfg_sel   = sel;
    cfg_lock  = lck;
    tick();
    cfg_valid = 1'b0;
    cfg_lock  = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("wait_ready", 64'(cfg_ready), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_lock  = 1'b0;
    cfg_pad   = '0;
    cfg_sel   = 2'd0;
    gpio_o    = 38'h2A_AAAA_AAAA;
    gpio_oe   = '1;
    alt0_o    = 38'h15_5555_5555;
    alt0_oe   = '1;
    alt1_o    = 38'h0F_0F0F_0F0F;
    alt1_oe   = 38'h3F_0000_FFFF;
    io_in     = '0;
    alt0_o[33] = 1'b1;

    // Reset state and GPIO pass-through
    repeat (3) tick();
    check("rst_oeb",   64'(io_oeb),    64'h3F_FFFF_FFFF);
    check("rst_ready", 64'(cfg_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 64'(cfg_ready), 64'd1);
    tick();
    check("gpio_out", 64'(io_out), 64'h2A_AAAA_AAAA);
    check("gpio_oeb", 64'(io_oeb), 64'd0);

    // Switch pad 33 to ALT0
    req(33, 2'd1, 1'b0);
    check("sw33_ready_t1", 64'(cfg_ready), 64'd0);
    tick();
    check("sw33_oeb_t2", 64'(io_oeb[33]), 64'd1);
    check("sw33_out_t2", 64'(io_out[33]), 64'd0);
    tick();
    check("sw33_ready_t3", 64'(cfg_ready), 64'd0);
    tick();
    check("sw33_oeb_t4",   64'(io_oeb[33]), 64'd1);
    check("sw33_ready_t4", 64'(cfg_ready),  64'd1);
    tick();
    check("sw33_out_t5", 64'(io_out[33]), 64'd1);
    check("sw33_oeb_t5", 64'(io_oeb[33]), 64'd0);

    // Out-of-range pad
    req(40, 2'd1, 1'b0);
    check("bad_pad_err",   64'(cfg_err),   64'd1);
    check("bad_pad_ready", 64'(cfg_ready), 64'd1);
    tick();
    check("bad_pad_err_clr", 64'(cfg_err), 64'd0);

    // Same select: no gap
    req(12, 2'd0, 1'b0);
    check("same_sel_ready", 64'(cfg_ready), 64'd1);
    check("same_sel_err",   64'(cfg_err),   64'd0);
    tick();

    // Lock on pad 5, then a rejected request for pad 6
    req(5, 2'd3, 1'b1);
    check("lock_set", 64'(locked_o), 64'd1);
    wait_ready();
    tick();
    check("pad5_oeb", 64'(io_oeb[5]), 64'd1);
    check("pad5_out", 64'(io_out[5]), 64'd0);
    req(6, 2'd2, 1'b0);
    check("locked_err", 64'(cfg_err), 64'd1);
    tick();
    tick();
    check("pad6_oeb", 64'(io_oeb[6]), 64'd0);
    check("pad6_out", 64'(io_out[6]), 64'd0);

    // Synchronizer latency on io_in[7]
    io_in[7] = 1'b1;
    check("sync_c0", 64'(pad_in_o[7]), 64'd0);
    tick();
    check("sync_c1", 64'(pad_in_o[7]), 64'd0);
    tick();
    check("sync_c2", 64'(pad_in_o[7]), 64'd1);

    // Reset mid-switch of pad 10 aborts it
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("unlock_after_rst", 64'(locked_o), 64'd0);
    alt1_oe[10] = 1'b0;
    req(10, 2'd2, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("pad10_oeb_gpio", 64'(io_oeb[10]), 64'd0);
    gpio_oe[10] = 1'b0;
    tick();
    check("pad10_oeb_follow", 64'(io_oeb[10]), 64'd1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/azadi_pad_mux.md
AZADI_PAD_MUX -- requirements
Module: azadi_pad_mux

Interface
REQ-001 Parameter NUM_PADS, default 38, number of Caravel IO pads handled.
REQ-002 Parameter PAD_IDX_W, default 6, width of pad index; SHALL satisfy 2**PAD_IDX_W >= NUM_PADS.
REQ-003 Parameter SYNC_STAGES, default 2, input synchronizer depth; legal range 2..4.
REQ-004 Parameter GAP_CYCLES, default 2, tri-state gap inserted on function change; legal range 1..15.
REQ-005 Parameter RESET_SEL, default 2'd0, per-pad function select loaded at reset.
REQ-006 wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-007 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-008 cfg_valid  in  1  configuration request.
REQ-009 cfg_ready  out  1  block can accept a request.
REQ-010 cfg_pad  in  PAD_IDX_W  target pad index.
REQ-011 cfg_sel  in  2  function: 0 GPIO, 1 ALT0, 2 ALT1, 3 input-only.
REQ-012 cfg_lock  in  1  sampled with an accepted request; sets sticky lock.
REQ-013 cfg_err  out  1  one-cycle pulse: request rejected.
REQ-014 locked_o  out  1  sticky lock status.
REQ-015 gpio_o, gpio_oe  in  NUM_PADS each  GPIO source per pad (oe active-high).
REQ-016 alt0_o, alt0_oe, alt1_o, alt1_oe  in  NUM_PADS each  alternate sources (SPI, UART, PWM...).
REQ-017 pad_in_o  out  NUM_PADS  synchronized io_in, to all core consumers.
REQ-018 io_in  in  NUM_PADS  pad inputs.
REQ-019 io_out, io_oeb  out  NUM_PADS each  registered pad drive; io_oeb active-low.

Function
REQ-020 Per-pad 2-bit select register sel_q[p]; one shared control FSM: IDLE, GAP, COMMIT.
REQ-021 Next drive per pad: sel 0 -> (gpio_o, ~gpio_oe); 1 -> (alt0_o, ~alt0_oe); 2 -> (alt1_o, ~alt1_oe); 3 -> (0, 1); io_out/io_oeb register this one cycle later.
REQ-022 Pad under switch (GAP or COMMIT, pad == stored index): next drive forced (0, 1).
REQ-023 cfg_ready = 1 only in IDLE and not in reset; accept when cfg_valid & cfg_ready in cycle T.
REQ-024 Reject (cfg_err = 1 in T+1, no state change, stay IDLE): cfg_pad >= NUM_PADS, or locked_o = 1.
REQ-025 Accepted with cfg_sel == sel_q[cfg_pad]: no gap, stay IDLE, no error; cfg_lock still honoured.
REQ-026 Accepted with differing cfg_sel: latch pad/sel, enter GAP for cycles T+1..T+GAP_CYCLES (4-bit down-counter), COMMIT in T+GAP_CYCLES+1 (sel_q written at its end), IDLE from T+GAP_CYCLES+2.
REQ-027 Resulting pad timing: io_oeb[p] = 1, io_out[p] = 0 for cycles T+2..T+GAP_CYCLES+2; new function visible from T+GAP_CYCLES+3.
REQ-028 Other pads unaffected throughout a switch.
REQ-029 cfg_lock = 1 on accepted, non-rejected request: locked_o = 1 from T+1, after that request completes; cleared only by reset.
REQ-030 cfg_valid ignored outside IDLE; requester holds request until ready (no queueing).
REQ-031 pad_in_o[p] = io_in[p] delayed exactly SYNC_STAGES cycles through a flop chain; no other filtering.
REQ-032 No combinational path from any input to io_out, io_oeb, pad_in_o, cfg_err.

Reset
REQ-033 While wb_rst_i = 1 at an edge: sel_q all = RESET_SEL, FSM IDLE, counter 0, locked_o 0, cfg_err 0, sync flops 0, io_out all 0, io_oeb all 1.
REQ-034 cfg_ready = 0 during reset, 1 in the first cycle after wb_rst_i deasserts.
REQ-035 Reset during GAP/COMMIT aborts the switch; sel_q[p] = RESET_SEL, never the pending value.

Verification
REQ-036 Reset, then gpio_oe = all 1, gpio_o = 38'h2A_AAAA_AAAA -> io_out = 38'h2A_AAAA_AAAA, io_oeb = 0 one cycle after drive; io_oeb all 1 during reset.
REQ-037 GAP_CYCLES=2, request pad 33 sel 1 at T, alt0_oe[33]=1, alt0_o[33]=1 -> io_oeb[33]=1 for T+2..T+4, io_out[33]=1/io_oeb[33]=0 from T+5, cfg_ready low T+1..T+3.
REQ-038 Request pad 40 (>= 38) -> cfg_err pulse at T+1, all sel_q unchanged, cfg_ready stays 1.
REQ-039 Request pad 5 sel 3 with cfg_lock=1, then pad 6 sel 2 -> first completes, locked_o=1; second gives cfg_err, pad 6 unchanged.
REQ-040 Toggle io_in[7] 0->1 at cycle C -> pad_in_o[7] rises at C+SYNC_STAGES (C+2 default).
REQ-041 wb_rst_i asserted at T+2 during switch of pad 10 to sel 2 -> after reset sel_q[10]=RESET_SEL, io_oeb[10] follows ~gpio_oe[10].
